// File: rtl/i2c_cmd_seq.sv
// i2c_cmd_seq: turns one APB-posted I2C descriptor (address, direction,
// byte count) into byte-level commands for the I2C master core.
// It buffers write bytes (TX FIFO) and read bytes (RX FIFO), and reports
// when the transaction ends and whether the slave NACKed.
// Optional per-command timeout: define I2C_CMD_TIMEOUT_EN. This adds the
// tmo_err port and a TMO_CYC watchdog on every outstanding command.

// Synchronous first-word-fall-through byte FIFO.
module i2c_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head is forced to zero while empty so the output is defined out of reset.
  assign rdata   = empty ? 8'h00 : mem[rptr];

  // Storage array: no reset needed, contents are only seen through rdata.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally (DEPTH is a power of 2); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module i2c_cmd_seq #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5,
  parameter int TMO_CYC    = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [6:0]       slv_addr,
  input  logic             rw,
  input  logic [CNT_W-1:0] byte_cnt,
  input  logic             tx_push,
  input  logic [7:0]       tx_data,
  input  logic             rx_pop,
  output logic [7:0]       rx_data,
  output logic             tx_full,
  output logic             rx_empty,
  output logic             busy,
  output logic             done,
  output logic             nack_err,
`ifdef I2C_CMD_TIMEOUT_EN
  output logic             tmo_err,
`endif
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [2:0]       cmd_code,
  output logic [7:0]       cmd_data,
  input  logic             core_done,
  input  logic             core_ack,
  input  logic [7:0]       core_rdata
);
  localparam logic [2:0] C_START    = 3'd0;
  localparam logic [2:0] C_WRITE    = 3'd1;
  localparam logic [2:0] C_RD_ACK   = 3'd2;
  localparam logic [2:0] C_RD_NACK  = 3'd3;
  localparam logic [2:0] C_STOP     = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_ADDR, S_WR, S_RD, S_STOP, S_FIN} state_t;

  // Reject parameter sets where the count field cannot express a full FIFO.
  if (FIFO_DEPTH > (1 << CNT_W) - 1 || TMO_CYC < 2) begin : g_param_err
    $error("i2c_cmd_seq: CNT_W too narrow for FIFO_DEPTH, or TMO_CYC < 2");
  end

  state_t           state;
  logic [6:0]       addr_q;
  logic             rw_q;
  logic [CNT_W-1:0] remain;
  logic             outstanding;   // one command accepted, awaiting core_done

  logic             tx_empty, rx_full;
  logic [7:0]       tx_head;
  logic             accept, tx_pop_int, rx_push_int, go_ok, last_byte;
  logic             can_issue;
  logic [2:0]       next_code;
  logic [7:0]       next_data;

  assign accept      = cmd_valid && cmd_ready;
  assign tx_pop_int  = accept && (state == S_WR);
  assign rx_push_int = outstanding && core_done && (state == S_RD);
  assign go_ok       = (byte_cnt != '0) && (byte_cnt <= CNT_W'(FIFO_DEPTH));
  assign last_byte   = (remain == CNT_W'(1));

  i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (tx_data),
    .pop   (tx_pop_int),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push_int),
    .wdata (core_rdata),
    .pop   (rx_pop),
    .rdata (rx_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Command the current state wants to issue, and whether it may issue it now.
  // WR stalls on an empty TX FIFO; RD stalls on a full RX FIFO so that the
  // byte returned by core_done always has a slot.
  always_comb begin
    can_issue = 1'b0;
    next_code = C_START;
    next_data = 8'h00;
    case (state)
      S_START: begin can_issue = 1'b1; next_code = C_START; end
      S_ADDR:  begin can_issue = 1'b1; next_code = C_WRITE; next_data = {addr_q, rw_q}; end
      S_WR:    begin can_issue = !tx_empty; next_code = C_WRITE; next_data = tx_head; end
      S_RD:    begin can_issue = !rx_full; next_code = last_byte ? C_RD_NACK : C_RD_ACK; end
      S_STOP:  begin can_issue = 1'b1; next_code = C_STOP; end
      default: can_issue = 1'b0;
    endcase
  end

`ifdef I2C_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  assign tmo_hit = outstanding && !core_done && (tmo_cnt == TW'(TMO_CYC - 1));
`endif

  // Transaction FSM with registered command/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      remain      <= '0;
      outstanding <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      nack_err    <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_code    <= C_START;
      cmd_data    <= 8'h00;
`ifdef I2C_CMD_TIMEOUT_EN
      tmo_err     <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        cmd_valid   <= 1'b0;
        outstanding <= 1'b1;
      end
`ifdef I2C_CMD_TIMEOUT_EN
      if (accept)           tmo_cnt <= '0;
      else if (outstanding) tmo_cnt <= tmo_cnt + TW'(1);
`endif
      case (state)
        // FIN is the done cycle; it also accepts a new go so none is lost.
        S_IDLE, S_FIN: begin
          state <= S_IDLE;
          if (go) begin
            nack_err <= 1'b0;
`ifdef I2C_CMD_TIMEOUT_EN
            tmo_err  <= 1'b0;
`endif
            if (go_ok) begin
              addr_q    <= slv_addr;
              rw_q      <= rw;
              remain    <= byte_cnt;
              busy      <= 1'b1;
              state     <= S_START;
              cmd_valid <= 1'b1;       // START goes out the cycle after go
              cmd_code  <= C_START;
              cmd_data  <= 8'h00;
            end else begin
              done <= 1'b1;            // bad count: finish immediately
            end
          end
        end
        default: begin
          if (!cmd_valid && !outstanding && can_issue) begin
            cmd_valid <= 1'b1;
            cmd_code  <= next_code;
            cmd_data  <= next_data;
          end
          if (outstanding && core_done) begin
            outstanding <= 1'b0;
            case (state)
              S_START: state <= S_ADDR;
              S_ADDR: begin
                if (core_ack) begin
                  nack_err <= 1'b1;
                  state    <= S_STOP;
                end else begin
                  state <= rw_q ? S_RD : S_WR;
                end
              end
              S_WR: begin
                if (core_ack) begin
                  nack_err <= 1'b1;
                  state    <= S_STOP;
                end else begin
                  if (remain != '0) remain <= remain - CNT_W'(1);
                  if (last_byte)    state  <= S_STOP;
                end
              end
              S_RD: begin
                if (remain != '0) remain <= remain - CNT_W'(1);
                if (last_byte)    state  <= S_STOP;
              end
              S_STOP: begin
                state <= S_FIN;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
`ifdef I2C_CMD_TIMEOUT_EN
      // Watchdog overrides everything: abandon the transaction without STOP.
      if (tmo_hit) begin
        tmo_err     <= 1'b1;
        state       <= S_FIN;
        done        <= 1'b1;
        busy        <= 1'b0;
        outstanding <= 1'b0;
        cmd_valid   <= 1'b0;
      end
`endif
    end
  end
endmodule

// File: doc/i2c_cmd_seq.md
Name: i2c_cmd_seq

Overview:
- Transaction sequencer between the APB register block and the I2C master core.
- The APB side posts one descriptor (slave address, direction, byte count) plus write bytes. The block breaks it into byte-level core commands (START, WRITE, READ, STOP), buffers read data, and reports completion or NACK.
- Sits upstream of the I2C master core; the APB block reads its status and RX FIFO.

Parameters:
- FIFO_DEPTH, 16, entries in each of the TX and RX byte FIFOs (power of 2).
- CNT_W, 5, width of the byte-count field; must hold FIFO_DEPTH.
- TMO_CYC, 4096, clk cycles allowed per core command before timeout (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- go  in  1  one-cycle pulse; starts the transaction described by slv_addr/rw/byte_cnt
- slv_addr  in  7  7-bit I2C slave address
- rw  in  1  1 = read, 0 = write
- byte_cnt  in  CNT_W  data bytes to transfer, 1..FIFO_DEPTH
- tx_push  in  1  push tx_data into TX FIFO
- tx_data  in  8  write byte
- rx_pop  in  1  pop RX FIFO head
- rx_data  out  8  RX FIFO head, valid when !rx_empty
- tx_full  out  1  TX FIFO full
- rx_empty  out  1  RX FIFO empty
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- nack_err  out  1  sticky; set on NACK, cleared by go
- cmd_valid  out  1  command to core valid
- cmd_ready  in  1  core accepts command
- cmd_code  out  3  0 START, 1 WRITE, 2 READ_ACK, 3 READ_NACK, 4 STOP
- cmd_data  out  8  byte for WRITE
- core_done  in  1  one-cycle pulse: accepted command finished
- core_ack  in  1  slave ACK (0 = ACK) sampled with core_done for START-addr/WRITE
- core_rdata  in  8  read byte, valid with core_done on READ_*

Behaviour:
- Reset: all outputs 0 except rx_empty = 1; FSM to IDLE; both FIFOs emptied; counters 0.
- FIFOs:
  - Synchronous, first-word-fall-through.
  - Push when full is ignored; pop when empty is ignored.
  - Simultaneous push and pop on a non-empty FIFO keeps the count.
  - Pointers wrap modulo FIFO_DEPTH.
- Handshake: a command transfers on cmd_valid & cmd_ready. cmd_valid holds with stable code/data until accepted. After acceptance the block waits for core_done; exactly one command is outstanding.
- FSM states: IDLE, START, ADDR, WR, RD, STOP, FIN.
- IDLE:
  - go with byte_cnt in 1..FIFO_DEPTH → latch descriptor, clear nack_err, busy=1, go to START.
  - go with byte_cnt = 0 or > FIFO_DEPTH → done pulse next cycle, nack_err=0, stay IDLE.
  - go while busy is ignored.
- START: issue START; on core_done go to ADDR.
- ADDR: issue WRITE with cmd_data = {slv_addr, rw}. On core_done:
  - core_ack = 1 → nack_err=1, go to STOP.
  - Otherwise go to WR if rw = 0, RD if rw = 1.
- WR:
  - Issue WRITE with the TX FIFO head; pop on acceptance.
  - If the TX FIFO is empty, hold cmd_valid = 0 (stall) until a byte arrives.
  - On core_done: NACK → nack_err=1, go to STOP. Otherwise decrement the remaining count; at 0 go to STOP.
- RD:
  - Issue READ_ACK, or READ_NACK for the last byte.
  - On core_done push core_rdata into the RX FIFO and decrement the remaining count; at 0 go to STOP.
  - RX FIFO full: hold cmd_valid = 0 until space is available; never drop a byte.
- STOP: issue STOP; on core_done go to FIN.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- Latency: go → cmd_valid (START) = 1 cycle.
- The remaining-byte counter is CNT_W bits and never underflows.
- After a NACK, unsent TX bytes remain in the TX FIFO; software flushes them by reset.
- rst mid-transaction: immediate return to IDLE; no STOP issued; FIFOs cleared.

Optional Feature:
- Macro: I2C_CMD_TIMEOUT_EN.
- Defined:
  - A TMO_CYC-cycle counter restarts on each cmd acceptance.
  - Expiry before core_done sets an extra output tmo_err (sticky, cleared by go). FSM goes directly to FIN; done pulses; cmd_valid drops.
- Undefined: no counter, no tmo_err port; the FSM waits indefinitely for core_done.

Test Plan:
- Write 3 bytes to 0x50: push A1,B2,C3, go (rw=0, cnt=3), core always ACKs → commands START, WRITE 0xA0, WRITE A1/B2/C3, STOP; done once; nack_err=0; tx empty.
- Read 2 bytes from 0x21: go (rw=1, cnt=2), core returns 5A, 7E → commands START, WRITE 0x43, READ_ACK, READ_NACK, STOP; RX pops 5A then 7E; rx_empty=1 afterwards.
- Address NACK: core_ack=1 on the ADDR byte → STOP issued, no data commands, nack_err=1, done pulses.
- Backpressure: cmd_ready low 5 cycles on each command → cmd_code/cmd_data stable while waiting; same command sequence as the no-stall case.
- Write 2 bytes with only 1 pushed, second pushed 20 cycles later → cmd_valid low during the gap; transaction then completes normally.
- Reset asserted while in RD → next cycle busy=0, cmd_valid=0, rx_empty=1; a following go runs normally.
